alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_if.sv | 47 ++++
 rtl/alu_op_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Handshake and datapath-control bundle between the op sequencer and its datapath.
// The master side is the sequencer; the slave side is the datapath/memory.
interface alu_op_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int OP_WIDTH   = 5
);
    logic                  start;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] bus_data;

    logic                  PCout;
    logic                  MARin;
    logic                  IncPC;
    logic                  Zin;
    logic                  PCin;
    logic                  Read;
    logic                  MDRin;
    logic                  MDRout;
    logic                  IRin;
    logic                  Yin;
    logic                  Zlowout;
    logic                  Zhighout;
    logic                  LOin;
    logic                  HIin;

    logic [NUM_REGS-1:0]   reg_out_sel;
    logic [NUM_REGS-1:0]   reg_in_sel;
    logic [OP_WIDTH-1:0]   alu_op;
    logic                  busy;
    logic                  done;
    logic                  illegal;

    modport master (
        input  start, mem_ready, bus_data,
        output PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
               Zlowout, Zhighout, LOin, HIin,
               reg_out_sel, reg_in_sel, alu_op, busy, done, illegal
    );

    modport slave (
        output start, mem_ready, bus_data,
        input  PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
               Zlowout, Zhighout, LOin, HIin,
               reg_out_sel, reg_in_sel, alu_op, busy, done, illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Fetch/execute control sequencer for a bus-based ALU datapath: fetches one
// instruction, decodes its class and steps the datapath strobes through T0..T6.
module alu_op_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int OP_WIDTH   = 5
) (
    input logic                 Clock,
    input logic                 clear,
    alu_op_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, DONE, ILL
    } state_t;

    typedef enum logic [1:0] {
        CLS_ILLEGAL, CLS_BINARY, CLS_WIDE, CLS_UNARY
    } op_class_t;

    localparam int INSTR_BITS = 17;

    state_t                  state;
    state_t                  state_next;
    logic [INSTR_BITS-1:0]   ir;

    logic [4:0]              bus_op;
    logic [3:0]              bus_ra;
    logic [3:0]              bus_rb;
    logic [3:0]              bus_rc;
    logic [4:0]              ir_op;
    logic [3:0]              ir_ra;
    logic [3:0]              ir_rb;
    logic [3:0]              ir_rc;
    op_class_t               bus_cls;
    op_class_t               ir_cls;
    logic                    bus_legal;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t c;
        c = CLS_ILLEGAL;
        if (op >= 5'b00011 && op <= 5'b01011)
            c = CLS_BINARY;
        else if (op == 5'b01111 || op == 5'b10000)
            c = CLS_WIDE;
        else if (op == 5'b10001 || op == 5'b10010)
            c = CLS_UNARY;
        return c;
    endfunction

    function automatic logic reg_ok(input logic [3:0] r);
        return int'(r) < NUM_REGS;
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] r);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            if (r == 4'(i))
                v[i] = 1'b1;
        return v;
    endfunction

    // Only the register fields an opcode actually uses are range-checked.
    function automatic logic legal(input op_class_t c, input logic [3:0] ra,
                                   input logic [3:0] rb, input logic [3:0] rc);
        logic ok;
        case (c)
            CLS_BINARY: ok = reg_ok(ra) && reg_ok(rb) && reg_ok(rc);
            CLS_WIDE:   ok = reg_ok(rb) && reg_ok(rc);
            CLS_UNARY:  ok = reg_ok(ra) && reg_ok(rb);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign bus_op    = bus.bus_data[DATA_WIDTH-1  -: 5];
    assign bus_ra    = bus.bus_data[DATA_WIDTH-6  -: 4];
    assign bus_rb    = bus.bus_data[DATA_WIDTH-10 -: 4];
    assign bus_rc    = bus.bus_data[DATA_WIDTH-14 -: 4];
    assign bus_cls   = classify(bus_op);
    assign bus_legal = legal(bus_cls, bus_ra, bus_rb, bus_rc);

    assign ir_op     = ir[16:12];
    assign ir_ra     = ir[11:8];
    assign ir_rb     = ir[7:4];
    assign ir_rc     = ir[3:0];
    assign ir_cls    = classify(ir_op);

    always_ff @(posedge Clock) begin
        if (clear) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == T2)
                ir <= bus.bus_data[DATA_WIDTH-1 -: INSTR_BITS];
        end
    end

    // The T2 branch decodes the live bus word, since ir only captures it at the end of T2.
    always_comb begin
        state_next      = state;
        bus.PCout       = 1'b0;
        bus.MARin       = 1'b0;
        bus.IncPC       = 1'b0;
        bus.Zin         = 1'b0;
        bus.PCin        = 1'b0;
        bus.Read        = 1'b0;
        bus.MDRin       = 1'b0;
        bus.MDRout      = 1'b0;
        bus.IRin        = 1'b0;
        bus.Yin         = 1'b0;
        bus.Zlowout     = 1'b0;
        bus.Zhighout    = 1'b0;
        bus.LOin        = 1'b0;
        bus.HIin        = 1'b0;
        bus.reg_out_sel = '0;
        bus.reg_in_sel  = '0;
        bus.alu_op      = '0;
        bus.busy        = (state != IDLE);
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start)
                    state_next = T0;
            end
            T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zin    = 1'b1;
                state_next = T1;
            end
            T1: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
                if (bus.mem_ready) begin
                    bus.Zlowout = 1'b1;
                    bus.PCin    = 1'b1;
                    state_next  = T2;
                end
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                if (!bus_legal)
                    state_next = ILL;
                else if (bus_cls == CLS_UNARY)
                    state_next = T4;
                else
                    state_next = T3;
            end
            T3: begin
                bus.reg_out_sel = onehot(ir_rb);
                bus.Yin         = 1'b1;
                bus.alu_op      = OP_WIDTH'(ir_op);
                state_next      = T4;
            end
            T4: begin
                bus.Zin         = 1'b1;
                bus.reg_out_sel = (ir_cls == CLS_UNARY) ? onehot(ir_rb) : onehot(ir_rc);
                bus.alu_op      = OP_WIDTH'(ir_op);
                state_next      = T5;
            end
            T5: begin
                bus.Zlowout = 1'b1;
                bus.alu_op  = OP_WIDTH'(ir_op);
                if (ir_cls == CLS_WIDE) begin
                    bus.LOin   = 1'b1;
                    state_next = T6;
                end else begin
                    bus.reg_in_sel = onehot(ir_ra);
                    state_next     = DONE;
                end
            end
            T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.alu_op   = OP_WIDTH'(ir_op);
                state_next   = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = bus.start ? T0 : IDLE;
            end
            ILL: begin
                bus.done    = 1'b1;
                bus.illegal = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Checks the sequencer cycle by cycle against a per-instruction expected trace,
// using a 16-register and an 8-register instance driven one at a time.
module tb_alu_op_sequencer;

    localparam logic [13:0] S_PCOUT    = 14'h2000;
    localparam logic [13:0] S_MARIN    = 14'h1000;
    localparam logic [13:0] S_INCPC    = 14'h0800;
    localparam logic [13:0] S_ZIN      = 14'h0400;
    localparam logic [13:0] S_PCIN     = 14'h0200;
    localparam logic [13:0] S_READ     = 14'h0100;
    localparam logic [13:0] S_MDRIN    = 14'h0080;
    localparam logic [13:0] S_MDROUT   = 14'h0040;
    localparam logic [13:0] S_IRIN     = 14'h0020;
    localparam logic [13:0] S_YIN      = 14'h0010;
    localparam logic [13:0] S_ZLOWOUT  = 14'h0008;
    localparam logic [13:0] S_ZHIGHOUT = 14'h0004;
    localparam logic [13:0] S_LOIN     = 14'h0002;
    localparam logic [13:0] S_HIIN     = 14'h0001;

    typedef struct packed {
        logic [13:0] strb;
        logic [15:0] osel;
        logic [15:0] isel;
        logic [4:0]  op;
        logic        busy;
        logic        done;
        logic        ill;
    } obs_t;

    typedef struct {
        bit t2;
        bit mr_fixed;
        bit mr;
    } cyc_t;

    logic        Clock;
    logic        clear;
    logic        start;
    logic        mem_ready;
    logic [31:0] bus_data;
    logic        sel8;
    obs_t        obs;

    int total = 0;
    int bad   = 0;

    obs_t exp_q[$];
    cyc_t cyc_q[$];

    alu_op_sequencer_if #(.DATA_WIDTH(32), .NUM_REGS(16), .OP_WIDTH(5)) if16 ();
    alu_op_sequencer_if #(.DATA_WIDTH(32), .NUM_REGS(8),  .OP_WIDTH(5)) if8 ();

    alu_op_sequencer #(.DATA_WIDTH(32), .NUM_REGS(16), .OP_WIDTH(5)) dut16 (
        .Clock(Clock), .clear(clear), .bus(if16)
    );
    alu_op_sequencer #(.DATA_WIDTH(32), .NUM_REGS(8), .OP_WIDTH(5)) dut8 (
        .Clock(Clock), .clear(clear), .bus(if8)
    );

    assign if16.start     = sel8 ? 1'b0 : start;
    assign if16.mem_ready = sel8 ? 1'b0 : mem_ready;
    assign if16.bus_data  = sel8 ? 32'h0 : bus_data;
    assign if8.start      = sel8 ? start : 1'b0;
    assign if8.mem_ready  = sel8 ? mem_ready : 1'b0;
    assign if8.bus_data   = sel8 ? bus_data : 32'h0;

    always_comb begin
        obs = '0;
        if (!sel8) begin
            obs.strb = {if16.PCout, if16.MARin, if16.IncPC, if16.Zin, if16.PCin, if16.Read,
                        if16.MDRin, if16.MDRout, if16.IRin, if16.Yin, if16.Zlowout,
                        if16.Zhighout, if16.LOin, if16.HIin};
            obs.osel = if16.reg_out_sel;
            obs.isel = if16.reg_in_sel;
            obs.op   = if16.alu_op;
            obs.busy = if16.busy;
            obs.done = if16.done;
            obs.ill  = if16.illegal;
        end else begin
            obs.strb = {if8.PCout, if8.MARin, if8.IncPC, if8.Zin, if8.PCin, if8.Read,
                        if8.MDRin, if8.MDRout, if8.IRin, if8.Yin, if8.Zlowout,
                        if8.Zhighout, if8.LOin, if8.HIin};
            obs.osel = {8'h00, if8.reg_out_sel};
            obs.isel = {8'h00, if8.reg_in_sel};
            obs.op   = if8.alu_op;
            obs.busy = if8.busy;
            obs.done = if8.done;
            obs.ill  = if8.illegal;
        end
    end

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [15:0] oh(input int r);
        return 16'h0001 << r;
    endfunction

    function automatic void add(input logic [13:0] strb, input logic [15:0] osel,
                                input logic [15:0] isel, input logic [4:0] op,
                                input bit dn, input bit il, input bit t2,
                                input bit mr_fixed, input bit mr);
        obs_t e;
        cyc_t c;
        e.strb = strb; e.osel = osel; e.isel = isel; e.op = op;
        e.busy = 1'b1; e.done = dn; e.ill = il;
        c.t2 = t2; c.mr_fixed = mr_fixed; c.mr = mr;
        exp_q.push_back(e);
        cyc_q.push_back(c);
    endfunction

    // Expected outputs for every cycle from T0 to DONE/ILL; returns legality.
    function automatic bit build(input logic [31:0] ins, input int stalls, input int nregs);
        int op, ra, rb, rc;
        bit is_bin, is_wide, is_un, ok;
        op = int'(ins[31:27]); ra = int'(ins[26:23]);
        rb = int'(ins[22:19]); rc = int'(ins[18:15]);
        is_bin  = (op >= 3 && op <= 11);
        is_wide = (op == 15 || op == 16);
        is_un   = (op == 17 || op == 18);
        ok = (is_bin  && ra < nregs && rb < nregs && rc < nregs) ||
             (is_wide && rb < nregs && rc < nregs) ||
             (is_un   && ra < nregs && rb < nregs);
        exp_q.delete();
        cyc_q.delete();
        add(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < stalls; i++)
            add(S_READ | S_MDRIN, 0, 0, 0, 0, 0, 0, 1, 0);
        add(S_READ | S_MDRIN | S_ZLOWOUT | S_PCIN, 0, 0, 0, 0, 0, 0, 1, 1);
        add(S_MDROUT | S_IRIN, 0, 0, 0, 0, 0, 1, 0, 0);
        if (!ok) begin
            add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        end else begin
            if (!is_un)
                add(S_YIN, oh(rb), 0, 5'(op), 0, 0, 0, 0, 0);
            add(S_ZIN, is_un ? oh(rb) : oh(rc), 0, 5'(op), 0, 0, 0, 0, 0);
            if (is_wide) begin
                add(S_ZLOWOUT | S_LOIN, 0, 0, 5'(op), 0, 0, 0, 0, 0);
                add(S_ZHIGHOUT | S_HIIN, 0, 0, 5'(op), 0, 0, 0, 0, 0);
            end else begin
                add(S_ZLOWOUT, 0, oh(ra), 5'(op), 0, 0, 0, 0, 0);
            end
            add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        end
        return ok;
    endfunction

    task automatic check(input string tag, input int cyc, input obs_t want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, want);
        end
    endtask

    // IDLE cycle in which start is raised for the selected instance.
    task automatic kick(input bit use8);
        @(negedge Clock);
        sel8      = use8;
        start     = 1'b1;
        mem_ready = 1'($urandom);
        bus_data  = $urandom;
        #1;
        check("idle_kick", 0, '0);
    endtask

    task automatic run_txn(input string tag, input logic [31:0] ins, input int stalls,
                           input bit hold_start, input bit chain, input int abort_at,
                           output bit chained);
        bit ok;
        int n;
        ok = build(ins, stalls, sel8 ? 8 : 16);
        n = exp_q.size();
        chained = ok && chain && (abort_at < 0);
        for (int k = 0; k < n; k++) begin
            @(negedge Clock);
            bus_data  = cyc_q[k].t2 ? ins : $urandom;
            mem_ready = cyc_q[k].mr_fixed ? cyc_q[k].mr : 1'($urandom);
            if (k == n - 1)
                start = ok ? chained : hold_start;
            else
                start = hold_start;
            #1;
            check(tag, k + 1, exp_q[k]);
            if (k == abort_at) begin
                clear = 1'b1;
                @(negedge Clock);
                #1;
                check("clear_mid", k + 2, '0);
                clear = 1'b0;
                start = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        bit ch;
        logic [31:0] ins;
        int r;

        sel8 = 1'b0; clear = 1'b1; start = 1'b1; mem_ready = 1'b1; bus_data = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        #1;
        check("reset_vs_start", 0, '0);
        clear = 1'b0;
        start = 1'b0;

        kick(0); run_txn("s1_and",      32'h2A1B8000, 0, 0, 0, -1, ch);
        kick(0); run_txn("s2_mul",      32'h781B8000, 0, 0, 0, -1, ch);
        kick(0); run_txn("s3_not",      32'h92980000, 0, 0, 0, -1, ch);
        kick(0); run_txn("s4_stall",    32'h2A1B8000, 3, 0, 0, -1, ch);
        kick(0); run_txn("s5_op0",      32'h01234567, 0, 1, 0, -1, ch);
        kick(1); run_txn("s5_ra9_n8",   32'h2C9B8000, 0, 0, 0, -1, ch);
        kick(0); run_txn("s5_ra9_n16",  32'h2C9B8000, 0, 0, 0, -1, ch);
        kick(1); run_txn("s5_div_n8",   32'h80000000, 1, 0, 0, -1, ch);
        kick(0); run_txn("s6_clear",    32'h2A1B8000, 0, 1, 0, 4, ch);
        kick(0); run_txn("s6_b2b_a",    32'h2A1B8000, 0, 1, 1, -1, ch);
        if (ch) run_txn("s6_b2b_b", 32'h781B8000, 2, 1, 0, -1, ch);
        else    kick(0);

        ch = 1'b0;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            ins = $urandom;
            if (r < 4)      ins[31:27] = 5'($urandom_range(3, 11));
            else if (r < 6) ins[31:27] = 5'($urandom_range(15, 16));
            else if (r < 8) ins[31:27] = 5'($urandom_range(17, 18));
            if (!ch)
                kick(1'($urandom));
            run_txn("rand", ins, $urandom_range(0, 3), 1'($urandom),
                    (i < 59) && ($urandom_range(0, 2) == 0), -1, ch);
        end

        @(negedge Clock);
        start = 1'b0;
        #1;
        check("final_idle", 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
